mem_port_arbiter: RTL

//  Shares one single-ported unified memory between instruction fetch (IF) and the load/store path (DM).

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority DM > IF.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic          owner_dm;
    logic [TW-1:0] wdog;
    logic          pick_dm;
    logic          grant;
    logic          wd_fire;

    always_comb begin
`ifdef ARB_RR_EN
        // Owner holds the last grant; on contention the other side wins.
        pick_dm = dm_req && (!if_req || !owner_dm);
`else
        pick_dm = dm_req;
`endif
        grant   = (state == IDLE) && !rst && (if_req || dm_req);
        dm_gnt  = grant && pick_dm;
        if_gnt  = grant && !pick_dm;
        wd_fire = (TIMEOUT != 0) && (wdog == WD_LAST);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_dm    <= 1'b0;
            wdog        <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_valid    <= 1'b0;
            dm_valid    <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner_dm <= pick_dm;
                        mem_req  <= 1'b1;
                        mem_we   <= pick_dm && dm_we;
                        mem_addr <= pick_dm ? dm_addr : if_addr;
                        if (pick_dm) mem_wdata <= dm_wdata;
                        wdog     <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog <= wdog + 1'b1;
                    if (mem_ack || wd_fire) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        if_valid <= !owner_dm;
                        dm_valid <= owner_dm;
                        state    <= RESP;
                    end
                    if (mem_ack) begin
                        if (!mem_we) begin
                            if (owner_dm) dm_rdata <= mem_rdata;
                            else          if_rdata <= mem_rdata;
                        end
                    end else if (wd_fire) begin
                        if (owner_dm) dm_rdata <= '0;
                        else          if_rdata <= '0;
                        timeout_err <= 1'b1;
                    end
                end
                RESP: begin
                    wdog  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
